// File: rtl/gshare_pc_sel_unit.sv
`default_nettype none
// ============================================================================
// Module      : gshare_pc_sel_unit
// Description : Next-PC select generator for IF. Holds a gshare direction
//               predictor (BHR xor PC indexing 2-bit counters) and a
//               direct-mapped tagged BTB. Resolved branches from EX train
//               both tables and override the fetch prediction on mispredict.
// Revision    : 1.0 - initial release
// ============================================================================
module gshare_pc_sel_unit #(
  parameter int IDX_W = 5,
  parameter int XLEN  = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [XLEN-1:0]  if_pc,
  output logic [1:0]       pc_sel,
  output logic [XLEN-1:0]  pred_target,
  output logic             if_pred_taken,
  output logic [IDX_W-1:0] if_pht_idx,
  input  logic             ex_valid,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic             ex_taken,
  input  logic [XLEN-1:0]  ex_target,
  input  logic             ex_pred_taken,
  input  logic [XLEN-1:0]  ex_pred_target,
  input  logic [IDX_W-1:0] ex_pht_idx,
  output logic             flush
);

  localparam int          c_ENTRIES = 1 << IDX_W;
  localparam int          c_TAG_W   = XLEN - IDX_W - 2;
  localparam logic [1:0]  c_SEL_SEQ = 2'b00;
  localparam logic [1:0]  c_SEL_PRD = 2'b01;
  localparam logic [1:0]  c_SEL_TKN = 2'b10;
  localparam logic [1:0]  c_SEL_NTK = 2'b11;

  // Predictor state
  logic [IDX_W-1:0]   r_bhr;
  logic [1:0]         r_pht       [c_ENTRIES];
  logic [c_ENTRIES-1:0] r_btb_valid;
  logic [c_TAG_W-1:0] r_btb_tag   [c_ENTRIES];
  logic [XLEN-1:0]    r_btb_tgt   [c_ENTRIES];

  // Lookup / resolution wires
  logic [IDX_W-1:0]   w_btb_i;
  logic [IDX_W-1:0]   w_idx;
  logic               w_hit;
  logic               w_mis;
  logic [IDX_W-1:0]   w_ex_btb_i;
  logic               w_unused;

  // PC bits [1:0] never participate in indexing or tagging
  assign w_unused = ^{if_pc[1:0], ex_pc[1:0]};

  // Fetch-side lookup against pre-edge table contents
  always_comb begin
    w_btb_i       = if_pc[IDX_W+1:2];
    w_idx         = w_btb_i ^ r_bhr;
    w_hit         = r_btb_valid[w_btb_i] &&
                    (r_btb_tag[w_btb_i] == if_pc[XLEN-1:IDX_W+2]);
    if_pht_idx    = w_idx;
    if_pred_taken = w_hit && r_pht[w_idx][1];
    pred_target   = r_btb_tgt[w_btb_i];
  end

  // Mispredict detection and next-PC select; recovery outranks prediction
  always_comb begin
    w_mis  = ex_valid && ((ex_taken != ex_pred_taken) ||
                          (ex_taken && (ex_target != ex_pred_target)));
    pc_sel = c_SEL_SEQ;
    if (w_mis && ex_taken)       pc_sel = c_SEL_TKN;
    else if (w_mis)              pc_sel = c_SEL_NTK;
    else if (if_pred_taken)      pc_sel = c_SEL_PRD;
    flush  = w_mis;
  end

  assign w_ex_btb_i = ex_pc[IDX_W+1:2];

  // Global history: shift in resolved direction, EX only
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         r_bhr <= '0;
    else if (ex_valid) r_bhr <= {r_bhr[IDX_W-2:0], ex_taken};
  end

  // Saturating 2-bit counters, reset to weakly not-taken
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < c_ENTRIES; i++) r_pht[i] <= 2'b01;
    end else if (ex_valid) begin
      if (ex_taken) begin
        if (r_pht[ex_pht_idx] != 2'b11) r_pht[ex_pht_idx] <= r_pht[ex_pht_idx] + 2'b01;
      end else begin
        if (r_pht[ex_pht_idx] != 2'b00) r_pht[ex_pht_idx] <= r_pht[ex_pht_idx] - 2'b01;
      end
    end
  end

  // BTB valid bits are the only BTB state that needs clearing
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                     r_btb_valid <= '0;
    else if (ex_valid && ex_taken) r_btb_valid[w_ex_btb_i] <= 1'b1;
  end

  // BTB tag/target payload, written only by taken resolutions
  always_ff @(posedge clk) begin
    if (ex_valid && ex_taken) begin
      r_btb_tag[w_ex_btb_i] <= ex_pc[XLEN-1:IDX_W+2];
      r_btb_tgt[w_ex_btb_i] <= ex_target;
    end
  end

endmodule
`default_nettype wire
